// File: rtl/cardjitsu_pkg.sv
// rtl/cardjitsu_pkg.sv - shared encodings, FSM states and element ordering for the referee
package cardjitsu_pkg;

  typedef enum logic [1:0] {
    EL_FIRE    = 2'b00,
    EL_WATER   = 2'b01,
    EL_SNOW    = 2'b10,
    EL_INVALID = 2'b11
  } element_t;

  typedef enum logic [1:0] {
    WIN_TIE = 2'b00,
    WIN_P0  = 2'b01,
    WIN_P1  = 2'b10
  } winner_t;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_JUDGE,
    ST_REPORT,
    ST_DONE
  } state_t;

  // Cyclic dominance between the three valid elements.
  function automatic logic beats(input element_t a, input element_t b);
    return (a == EL_FIRE  && b == EL_SNOW)  ||
           (a == EL_SNOW  && b == EL_WATER) ||
           (a == EL_WATER && b == EL_FIRE);
  endfunction

endpackage

// File: rtl/cj_card_compare.sv
// rtl/cj_card_compare.sv - combinational two-card compare giving winner code and winning element
module cj_card_compare
  import cardjitsu_pkg::*;
#(
  parameter int VAL_W = 4
) (
  input  logic [VAL_W+1:0] card_a,
  input  logic [VAL_W+1:0] card_b,
  output logic [1:0]       winner,
  output logic [1:0]       win_elem
);

  element_t         ea;
  element_t         eb;
  logic [VAL_W-1:0] va;
  logic [VAL_W-1:0] vb;

  assign ea = element_t'(card_a[VAL_W+1:VAL_W]);
  assign eb = element_t'(card_b[VAL_W+1:VAL_W]);
  assign va = card_a[VAL_W-1:0];
  assign vb = card_b[VAL_W-1:0];

  always_comb begin
    winner = WIN_TIE;
    if (ea == EL_INVALID && eb == EL_INVALID) winner = WIN_TIE;
    else if (ea == EL_INVALID)                winner = WIN_P1;
    else if (eb == EL_INVALID)                winner = WIN_P0;
    else if (ea == eb)                        winner = (va > vb) ? WIN_P0 : (vb > va) ? WIN_P1 : WIN_TIE;
    else                                      winner = beats(ea, eb) ? WIN_P0 : WIN_P1;
  end

  assign win_elem = (winner == WIN_P1) ? eb : ea;

endmodule

// File: rtl/cardjitsu_referee.sv
// rtl/cardjitsu_referee.sv - card-jitsu round referee with match tally tracking
// Optional CJ_TIMEOUT_EN: forfeit a round when the second card never arrives.
module cardjitsu_referee
  import cardjitsu_pkg::*;
#(
  parameter int VAL_W       = 4,
  parameter int SAME_TARGET = 3,
  parameter int ROUND_W     = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               new_match,
  input  logic               p0_valid,
  input  logic [VAL_W+1:0]   p0_card,
  output logic               p0_ready,
  input  logic               p1_valid,
  input  logic [VAL_W+1:0]   p1_card,
  output logic               p1_ready,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [1:0]         result_winner,
  output logic               result_forfeit,
  output logic               match_over,
  output logic               match_winner,
  output logic [ROUND_W-1:0] round_cnt
);

  localparam int TW = $clog2(SAME_TARGET + 1);

  state_t           state;
  logic [VAL_W+1:0] slot0;
  logic [VAL_W+1:0] slot1;
  logic             full0;
  logic             full1;
  logic [TW-1:0]    tally [2][3];
  logic [TW-1:0]    nxt_tally [3];
  logic [1:0]       cmp_winner;
  logic [1:0]       cmp_elem;
  logic             win_p1;
  logic             has_winner;
  logic             hit_target;
  logic             all_seen;
  logic             decide_now;
  logic             take0;
  logic             take1;

`ifdef CJ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            forfeit_r;
  assign result_forfeit = forfeit_r;
`else
  // Always 0 here: the timeout path is compiled out.
  assign result_forfeit = (TIMEOUT_CYC < 0);
`endif

  cj_card_compare #(.VAL_W(VAL_W)) u_cmp (
    .card_a  (slot0),
    .card_b  (slot1),
    .winner  (cmp_winner),
    .win_elem(cmp_elem)
  );

  assign p0_ready     = ena && state == ST_COLLECT && !full0;
  assign p1_ready     = ena && state == ST_COLLECT && !full1;
  assign result_valid = ena && state == ST_REPORT;
  assign take0        = p0_valid && p0_ready;
  assign take1        = p1_valid && p1_ready;

  // Winner's tallies after this round, and whether they close the match.
  always_comb begin
    has_winner = cmp_winner != WIN_TIE;
    win_p1     = cmp_winner == WIN_P1;
    hit_target = 1'b0;
    all_seen   = 1'b1;
    for (int e = 0; e < 3; e++) begin
      nxt_tally[e] = tally[win_p1][e];
      if (has_winner && cmp_elem == 2'(e) && nxt_tally[e] != TW'(SAME_TARGET))
        nxt_tally[e] = nxt_tally[e] + 1'b1;
      if (nxt_tally[e] == TW'(SAME_TARGET)) hit_target = 1'b1;
      if (nxt_tally[e] == '0) all_seen = 1'b0;
    end
    decide_now = has_winner && (hit_target || all_seen);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_COLLECT;
      slot0         <= '0;
      slot1         <= '0;
      full0         <= 1'b0;
      full1         <= 1'b0;
      round_cnt     <= '0;
      result_winner <= WIN_TIE;
      match_over    <= 1'b0;
      match_winner  <= 1'b0;
      for (int p = 0; p < 2; p++)
        for (int e = 0; e < 3; e++) tally[p][e] <= '0;
`ifdef CJ_TIMEOUT_EN
      to_cnt    <= '0;
      forfeit_r <= 1'b0;
`endif
    end else if (ena) begin
      if (new_match) begin
        state         <= ST_COLLECT;
        full0         <= 1'b0;
        full1         <= 1'b0;
        round_cnt     <= '0;
        result_winner <= WIN_TIE;
        match_over    <= 1'b0;
        match_winner  <= 1'b0;
        for (int p = 0; p < 2; p++)
          for (int e = 0; e < 3; e++) tally[p][e] <= '0;
`ifdef CJ_TIMEOUT_EN
        to_cnt    <= '0;
        forfeit_r <= 1'b0;
`endif
      end else begin
        case (state)
          ST_COLLECT: begin
            if (take0) begin slot0 <= p0_card; full0 <= 1'b1; end
            if (take1) begin slot1 <= p1_card; full1 <= 1'b1; end
            if (full0 && full1) state <= ST_JUDGE;
`ifdef CJ_TIMEOUT_EN
            if (take0 || take1) to_cnt <= '0;
            else if (full0 != full1) begin
              if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                to_cnt        <= '0;
                state         <= ST_REPORT;
                result_winner <= full0 ? WIN_P0 : WIN_P1;
                forfeit_r     <= 1'b1;
                round_cnt     <= round_cnt + 1'b1;
              end else begin
                to_cnt <= to_cnt + 1'b1;
              end
            end
`endif
          end
          ST_JUDGE: begin
            result_winner <= cmp_winner;
            round_cnt     <= round_cnt + 1'b1;
            for (int e = 0; e < 3; e++) tally[win_p1][e] <= nxt_tally[e];
            if (decide_now) begin
              match_over   <= 1'b1;
              match_winner <= win_p1;
            end
`ifdef CJ_TIMEOUT_EN
            forfeit_r <= 1'b0;
`endif
            state <= ST_REPORT;
          end
          ST_REPORT: begin
            if (result_ready) begin
              if (match_over) state <= ST_DONE;
              else begin
                full0 <= 1'b0;
                full1 <= 1'b0;
                state <= ST_COLLECT;
              end
            end
          end
          ST_DONE: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cardjitsu_referee.sv
// tb/tb_cardjitsu_referee.sv - scoreboard bench for cardjitsu_referee (default build)
module tb_cardjitsu_referee;

  typedef logic [5:0] card_t;
  typedef struct {
    logic [1:0] win;
    logic [7:0] rc;
    logic       over;
    logic       mwin;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       new_match = 1'b0;
  logic       p0_valid = 1'b0;
  logic       p1_valid = 1'b0;
  card_t      p0_card = '0;
  card_t      p1_card = '0;
  logic       p0_ready, p1_ready;
  logic       result_valid;
  logic       result_ready = 1'b0;
  logic [1:0] result_winner;
  logic       result_forfeit;
  logic       match_over, match_winner;
  logic [7:0] round_cnt;

  int   checks = 0;
  int   failures = 0;
  int   tal [2][3];
  int   rc_m = 0;
  bit   over_m = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  cardjitsu_referee dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .new_match(new_match),
    .p0_valid(p0_valid), .p0_card(p0_card), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_card(p1_card), .p1_ready(p1_ready),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_winner(result_winner), .result_forfeit(result_forfeit),
    .match_over(match_over), .match_winner(match_winner), .round_cnt(round_cnt)
  );

  function automatic logic [1:0] ref_winner(input card_t a, input card_t b);
    logic [1:0] ea, eb;
    ea = a[5:4];
    eb = b[5:4];
    if (ea == 2'd3 && eb == 2'd3) return 2'b00;
    if (ea == 2'd3) return 2'b10;
    if (eb == 2'd3) return 2'b01;
    if (ea == eb) return (a[3:0] > b[3:0]) ? 2'b01 : (a[3:0] < b[3:0]) ? 2'b10 : 2'b00;
    return (int'(eb) == (int'(ea) + 2) % 3) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < 2; p++)
      for (int e = 0; e < 3; e++) tal[p][e] = 0;
    rc_m   = 0;
    over_m = 0;
  endtask

  task automatic model_round(input card_t c0, input card_t c1);
    exp_t  e;
    card_t wc;
    int    p, el;
    bit    all1, hit;
    e.win = ref_winner(c0, c1);
    rc_m  = (rc_m + 1) % 256;
    e.rc  = 8'(rc_m);
    e.over = 1'b0;
    e.mwin = 1'b0;
    if (e.win != 2'b00) begin
      p  = (e.win == 2'b10) ? 1 : 0;
      wc = (p == 1) ? c1 : c0;
      el = int'(wc[5:4]);
      if (tal[p][el] < 3) tal[p][el]++;
      all1 = 1; hit = 0;
      for (int i = 0; i < 3; i++) begin
        if (tal[p][i] == 0) all1 = 0;
        if (tal[p][i] >= 3) hit = 1;
      end
      e.over = all1 || hit;
      e.mwin = (p == 1);
    end
    over_m = e.over;
    sb.push_back(e);
  endtask

  // Offer both cards (p1 delayed by d1 cycles); returns at the negedge after the last accept.
  task automatic drive(input card_t c0, input card_t c1, input int d1);
    int t;
    bit a0, a1, h0, h1;
    model_round(c0, c1);
    p0_card = c0; p1_card = c1;
    p0_valid = 1'b1; p1_valid = (d1 == 0);
    a0 = 0; a1 = 0; t = 0;
    while (!(a0 && a1) && t < 100) begin
      h0 = p0_valid && p0_ready;
      h1 = p1_valid && p1_ready;
      @(negedge clk);
      if (h0) begin a0 = 1; p0_valid = 1'b0; end
      if (h1) begin a1 = 1; p1_valid = 1'b0; end
      t++;
      if (t >= d1 && !a1) p1_valid = 1'b1;
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    if (!(a0 && a1)) begin
      checks++; failures++;
      $display("FAIL accept_timeout got a0=%0d a1=%0d want 1 1", a0, a1);
    end
  endtask

  task automatic wait_rv(output bit ok);
    int n = 0;
    while (!result_valid && n < 20) begin @(negedge clk); n++; end
    ok = result_valid;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL result_timeout got result_valid=0 want 1");
    end
  endtask

  task automatic collect();
    bit   ok;
    exp_t e;
    wait_rv(ok);
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL sb_empty got result with no expectation want none");
    end else begin
      e = sb.pop_front();
      if (ok) begin
        checks++;
        if (result_winner !== e.win) begin failures++; $display("FAIL winner got %b want %b", result_winner, e.win); end
        checks++;
        if (round_cnt !== e.rc) begin failures++; $display("FAIL round_cnt got %0d want %0d", round_cnt, e.rc); end
        checks++;
        if (match_over !== e.over) begin failures++; $display("FAIL match_over got %b want %b", match_over, e.over); end
        checks++;
        if (result_forfeit !== 1'b0) begin failures++; $display("FAIL forfeit got %b want 0", result_forfeit); end
        if (e.over) begin
          checks++;
          if (match_winner !== e.mwin) begin failures++; $display("FAIL match_winner got %b want %b", match_winner, e.mwin); end
        end
      end
    end
    if (ok) begin
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
    end
  endtask

  task automatic do_new_match();
    new_match = 1'b1;
    @(negedge clk);
    new_match = 1'b0;
    model_clear();
    checks++;
    if (round_cnt !== 8'd0 || match_over !== 1'b0) begin
      failures++; $display("FAIL new_match_clear got rc=%0d over=%b want 0 0", round_cnt, match_over);
    end
    checks++;
    if (p0_ready !== 1'b1 || p1_ready !== 1'b1) begin
      failures++; $display("FAIL new_match_ready got %b%b want 11", p0_ready, p1_ready);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (p0_ready !== 1'b1 || p1_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b%b want 11", p0_ready, p1_ready); end
    checks++;
    if (result_valid !== 1'b0 || match_over !== 1'b0 || match_winner !== 1'b0) begin
      failures++; $display("FAIL reset_flags got rv=%b mo=%b mw=%b want 0 0 0", result_valid, match_over, match_winner);
    end
    checks++;
    if (round_cnt !== 8'd0 || result_winner !== 2'b00 || result_forfeit !== 1'b0) begin
      failures++; $display("FAIL reset_result got rc=%0d w=%b f=%b want 0 00 0", round_cnt, result_winner, result_forfeit);
    end
  endtask

  task automatic test_latency();
    drive(6'b00_0101, 6'b10_1001, 0);
    checks++;
    if (result_valid !== 1'b0) begin failures++; $display("FAIL latency_c1 got rv=%b want 0", result_valid); end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0) begin failures++; $display("FAIL latency_c2 got rv=%b want 0", result_valid); end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b1) begin failures++; $display("FAIL latency_c3 got rv=%b want 1", result_valid); end
    collect();
  endtask

  task automatic test_ties();
    do_new_match();
    drive(6'b01_0011, 6'b01_0011, 0); collect();
    drive(6'b11_0101, 6'b11_1000, 1); collect();
    drive(6'b00_0001, 6'b11_1111, 0); collect();
    drive(6'b11_1111, 6'b10_0000, 2); collect();
  endtask

  task automatic test_gap();
    do_new_match();
    drive(6'b10_0010, 6'b00_0001, 6); collect();
    drive(6'b01_0111, 6'b01_1000, 3); collect();
  endtask

  task automatic test_stall();
    bit ok;
    do_new_match();
    drive(6'b10_0111, 6'b01_0010, 0);
    wait_rv(ok);
    p0_valid = 1'b1; p0_card = 6'b00_1111;
    p1_valid = 1'b1; p1_card = 6'b00_0000;
    for (int i = 0; i < 10 && ok; i++) begin
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b1 || result_winner !== 2'b01 || round_cnt !== 8'd1) begin
        failures++; $display("FAIL stall_hold got rv=%b w=%b rc=%0d want 1 01 1", result_valid, result_winner, round_cnt);
      end
      checks++;
      if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got %b%b want 00", p0_ready, p1_ready); end
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    collect();
    drive(6'b00_0001, 6'b01_0001, 0); collect();
  endtask

  task automatic test_match_win();
    do_new_match();
    drive(6'b10_0001, 6'b00_0010, 0); collect();
    drive(6'b00_0001, 6'b01_0010, 0); collect();
    drive(6'b01_0001, 6'b10_0010, 0); collect();
    p0_valid = 1'b1; p1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (match_over !== 1'b1 || match_winner !== 1'b1 || result_valid !== 1'b0) begin
        failures++; $display("FAIL done_state got mo=%b mw=%b rv=%b want 1 1 0", match_over, match_winner, result_valid);
      end
      checks++;
      if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin failures++; $display("FAIL done_ready got %b%b want 00", p0_ready, p1_ready); end
      @(negedge clk);
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    do_new_match();
  endtask

  task automatic test_ena();
    bit ok;
    do_new_match();
    ena = 1'b0;
    p0_valid = 1'b1; p0_card = 6'b00_0100;
    #1;
    checks++;
    if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin failures++; $display("FAIL ena_ready got %b%b want 00", p0_ready, p1_ready); end
    repeat (3) @(negedge clk);
    p0_valid = 1'b0; ena = 1'b1;
    @(negedge clk);
    checks++;
    if (p0_ready !== 1'b1) begin failures++; $display("FAIL ena_capture got p0_ready=%b want 1", p0_ready); end
    drive(6'b01_0100, 6'b00_1100, 1);
    wait_rv(ok);
    ena = 1'b0;
    #1;
    checks++;
    if (result_valid !== 1'b0) begin failures++; $display("FAIL ena_rv got %b want 0", result_valid); end
    repeat (3) @(negedge clk);
    checks++;
    if (round_cnt !== 8'd1 || result_valid !== 1'b0) begin
      failures++; $display("FAIL ena_freeze got rc=%0d rv=%b want 1 0", round_cnt, result_valid);
    end
    ena = 1'b1;
    collect();
  endtask

  task automatic test_random();
    card_t c0, c1;
    do_new_match();
    for (int i = 0; i < 30; i++) begin
      if (over_m) do_new_match();
      c0 = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      c1 = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      drive(c0, c1, int'($urandom_range(0, 3)));
      collect();
    end
  endtask

  task automatic test_reset_in_report();
    bit   ok;
    exp_t e;
    if (over_m) do_new_match();
    drive(6'b00_0110, 6'b10_0001, 0);
    wait_rv(ok);
    rst_n = 1'b0;
    #1;
    checks++;
    if (result_valid !== 1'b0 || round_cnt !== 8'd0) begin
      failures++; $display("FAIL reset_report got rv=%b rc=%0d want 0 0", result_valid, round_cnt);
    end
    if (sb.size() > 0) e = sb.pop_front();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (p0_ready !== 1'b1 || p1_ready !== 1'b1 || result_valid !== 1'b0) begin
      failures++; $display("FAIL reset_collect got %b%b rv=%b want 11 0", p0_ready, p1_ready, result_valid);
    end
    drive(6'b00_0001, 6'b01_0001, 0); collect();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_latency();
    test_ties();
    test_gap();
    test_stall();
    test_match_win();
    test_ena();
    test_random();
    test_reset_in_report();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
